spi_controller: RTL

SPI initiator that generates 16-bit write frames (nCS, SCLK, COPI) toward the on-chip `spi_peripheral` register bank. The frames set the output-enable, PWM-enable and duty-cycle registers. Used as a bring-up and self-test master and as the bench driver that replaces the external MCU. A simple valid/ready command port feeds it, and an optional read path samples CIPO.

---
 rtl/spi_ctrl_pkg.sv | 32 +++
 rtl/spi_ctrl_clkgen.sv | 47 ++++
 rtl/spi_controller.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI write-frame initiator.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam logic RW_WRITE = 1'b1;

  localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/spi_ctrl_clkgen.sv
// SCLK generator: counts CLK_DIV-cycle half periods while the frame is shifting.
module spi_ctrl_clkgen
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  input  logic stop,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb,
  output logic low_end_stb
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          phase_end;

  assign phase_end   = run && (cnt == CW'(CLK_DIV - 1));
  assign fall_stb    = phase_end && sclk;
  assign low_end_stb = phase_end && !sclk;
  // The last bit's low phase ends without another rise.
  assign rise_stb    = start || (low_end_stb && !stop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk <= 1'b0;
      cnt  <= '0;
    end else if (rise_stb) begin
      sclk <= 1'b1;
      cnt  <= '0;
    end else if (fall_stb) begin
      sclk <= 1'b0;
      cnt  <= '0;
    end else if (run && !phase_end) begin
      cnt  <= cnt + CW'(1);
    end else begin
      sclk <= 1'b0;
      cnt  <= '0;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator for 16-bit {rw, addr, data} frames to spi_peripheral.
// Define SPI_CTRL_READ_EN to honour cmd_rw and capture the read byte from CIPO.
module spi_controller
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              nCS,
  output logic              SCLK,
  output logic              COPI,
  input  logic              CIPO
);

  localparam int PH_MAX = max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP);
  localparam int PH_W   = $clog2(PH_MAX);

  state_t              state, state_d;
  logic [PH_W-1:0]     dly_cnt;
  logic [3:0]          bit_cnt;
  logic [FRAME_W-1:0]  shreg;
  logic [FRAME_W-1:0]  frame_in;
  logic                accept, setup_end, hold_end, gap_end, last_bit;
  logic                rise_stb, fall_stb, low_end_stb;

  assign accept    = cmd_valid && cmd_ready;
  assign setup_end = (state == ST_SETUP) && (dly_cnt == PH_W'(CS_SETUP - 1));
  assign hold_end  = (state == ST_HOLD)  && (dly_cnt == PH_W'(CS_HOLD - 1));
  assign gap_end   = (state == ST_GAP)   && (dly_cnt == PH_W'(CS_GAP - 1));
  assign last_bit  = (bit_cnt == 4'd0);

  spi_ctrl_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (setup_end),
    .run         (state == ST_SHIFT),
    .stop        (last_bit),
    .sclk        (SCLK),
    .rise_stb    (rise_stb),
    .fall_stb    (fall_stb),
    .low_end_stb (low_end_stb)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:  if (accept)                  state_d = ST_SETUP;
      ST_SETUP: if (setup_end)               state_d = ST_SHIFT;
      ST_SHIFT: if (low_end_stb && last_bit) state_d = ST_HOLD;
      ST_HOLD:  if (hold_end)                state_d = ST_GAP;
      ST_GAP:   if (gap_end)                 state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so nCS/done line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dly_cnt   <= '0;
      bit_cnt   <= 4'd0;
      nCS       <= 1'b1;
      COPI      <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_d;
      if ((state_d != state) || (state == ST_IDLE) || (state == ST_SHIFT))
        dly_cnt <= '0;
      else
        dly_cnt <= dly_cnt + PH_W'(1);
      if (accept)
        bit_cnt <= 4'd15;
      else if (rise_stb && (state == ST_SHIFT))
        bit_cnt <= bit_cnt - 4'd1;
      if (accept)
        COPI <= frame_in[FRAME_W-1];
      else if (fall_stb && !last_bit)
        COPI <= shreg[FRAME_W-2];
      nCS       <= !((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD));
      cmd_ready <= (state_d == ST_IDLE);
      busy      <= (state_d != ST_IDLE);
      done      <= hold_end;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      shreg <= frame_in;
    else if (fall_stb && !last_bit)
      shreg <= {shreg[FRAME_W-2:0], 1'b0};
  end

`ifdef SPI_CTRL_READ_EN
  logic              is_read;
  logic [DATA_W-1:0] rd_sh;

  assign frame_in = {cmd_rw, cmd_addr, cmd_data};

  // CIPO is taken on the last clk of each high phase of bits 7..0.
  always_ff @(posedge clk) begin
    if (accept)
      is_read <= (cmd_rw != RW_WRITE);
    if (fall_stb && is_read && (bit_cnt < 4'd8))
      rd_sh <= {rd_sh[DATA_W-2:0], CIPO};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= hold_end && is_read;
      if (hold_end && is_read)
        rd_data <= rd_sh;
    end
  end
`else
  logic unused_rd;

  assign frame_in  = {RW_WRITE, cmd_addr, cmd_data};
  assign rd_data   = '0;
  assign rd_valid  = 1'b0;
  assign unused_rd = CIPO ^ cmd_rw;
`endif

endmodule
